// File: rtl/bitmanip_pkg.sv
// bitmanip_pkg: shared op codes, FSM state type and datapath width default for bitmanip_alu
package bitmanip_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SLL    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_MUL    = 4'b0110;
    localparam logic [3:0] ALU_XOR    = 4'b0111;
    localparam logic [3:0] ALU_GRUP   = 4'b1001;
    localparam logic [3:0] ALU_DEGRUP = 4'b1010;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/bitmanip_grup_iter.sv
// bitmanip_grup_iter: bit-serial GRUP/DEGRUP engine, built only when BITMANIP_ALU_GRUP_EN is defined
`ifdef BITMANIP_ALU_GRUP_EN
module bitmanip_grup_iter
    import bitmanip_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     step,
    input  logic                     inverse,
    input  logic [XLEN-1:0]          src,
    input  logic [XLEN-1:0]          mask,
    input  logic [$clog2(XLEN)-1:0]  idx,
    output logic [XLEN-1:0]          res_next
);
    localparam int IW = $clog2(XLEN);
    logic [XLEN-1:0] src_q, mask_q, acc;
    logic [IW-1:0] lo, hi;
    logic [IW:0] zeros;
    logic inv_q;
    // number of zero mask bits: where the upper group begins
    always_comb begin
        zeros = '0;
        for (int i = 0; i < XLEN; i++) zeros = zeros + {{IW{1'b0}}, ~mask[i]};
    end
    // place one bit per step: pack into lo/hi slots, or unpack from them
    always_comb begin
        res_next = acc;
        if (inv_q) res_next[idx] = mask_q[idx] ? src_q[hi] : src_q[lo];
        else res_next[mask_q[idx] ? hi : lo] = src_q[idx];
    end
    // operand capture on start, pointer advance on each step
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            src_q  <= '0;
            mask_q <= '0;
            acc    <= '0;
            lo     <= '0;
            hi     <= '0;
            inv_q  <= 1'b0;
        end else if (start) begin
            src_q  <= src;
            mask_q <= mask;
            acc    <= '0;
            lo     <= '0;
            hi     <= zeros[IW-1:0];
            inv_q  <= inverse;
        end else if (step) begin
            acc <= res_next;
            if (mask_q[idx]) hi <= hi + 1'b1;
            else lo <= lo + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/bitmanip_alu.sv
// bitmanip_alu: handshaked ALU, single-cycle logic/add/shift, iterative MUL; GRUP/DEGRUP with BITMANIP_ALU_GRUP_EN
module bitmanip_alu
    import bitmanip_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic            regwrite_control,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            zero,
    output logic            illegal
);
    localparam int IW = $clog2(XLEN);
    state_t state, state_next;
    logic [IW-1:0] count;
    logic [XLEN-1:0] mul_a, mul_b, acc, mul_sum, alu_res, fin;
    logic bad, iter, accept, last;

    assign accept  = state == IDLE && in_valid;
    assign last    = state == BUSY && count == IW'(XLEN - 1);
    assign mul_sum = acc + (mul_b[0] ? mul_a : '0);

`ifdef BITMANIP_ALU_GRUP_EN
    logic mul_op;
    logic [XLEN-1:0] grup_res;
    assign iter = alu_control inside {ALU_MUL, ALU_GRUP, ALU_DEGRUP};
    assign fin  = mul_op ? mul_sum : grup_res;
    bitmanip_grup_iter #(.XLEN(XLEN)) u_grup (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (accept),
        .step     (state == BUSY),
        .inverse  (alu_control == ALU_DEGRUP),
        .src      (rs1),
        .mask     (rs2),
        .idx      (count),
        .res_next (grup_res)
    );
    // remember whether the running iteration is a multiply or a grouping op
    always_ff @(posedge clock) begin
        if (!reset_n) mul_op <= 1'b0;
        else if (accept) mul_op <= alu_control == ALU_MUL;
    end
`else
    assign iter = alu_control == ALU_MUL;
    assign fin  = mul_sum;
`endif

    // single-cycle datapath and legality decode
    always_comb begin
        alu_res = '0;
        bad     = 1'b0;
        case (alu_control)
            ALU_AND: alu_res = rs1 & rs2;
            ALU_OR:  alu_res = rs1 | rs2;
            ALU_ADD: alu_res = rs1 + rs2;
            ALU_SUB: alu_res = rs1 - rs2;
            ALU_XOR: alu_res = rs1 ^ rs2;
            ALU_SLL: alu_res = rs1 << rs2[IW-1:0];
            ALU_SRL: alu_res = rs1 >> rs2[IW-1:0];
            ALU_MUL: ;
`ifdef BITMANIP_ALU_GRUP_EN
            ALU_GRUP, ALU_DEGRUP: ;
`endif
            default: bad = 1'b1;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = iter ? BUSY : DONE;
            BUSY:    if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // operand capture, shift-add multiply and registered results
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count        <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            acc          <= '0;
            result       <= '0;
            zero         <= 1'b0;
            illegal      <= 1'b0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
        end else if (accept) begin
            count        <= '0;
            mul_a        <= rs1;
            mul_b        <= rs2;
            acc          <= '0;
            out_rd       <= in_rd;
            illegal      <= bad;
            out_regwrite <= regwrite_control & ~bad;
            if (!iter) begin
                result <= alu_res;
                zero   <= alu_res == '0;
            end
        end else if (state == BUSY) begin
            count <= count + 1'b1;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            acc   <= mul_sum;
            if (last) begin
                result <= fin;
                zero   <= fin == '0;
            end
        end
    end
endmodule

// File: doc/bitmanip_alu.md
# bitmanip_alu

Multi-cycle execution unit consuming the 4-bit `alu_control` code and `regwrite_control` produced by the R-type instruction decoder. It executes logic, add/sub, and shift operations in one cycle. MUL, GRUP and DEGRUP are iterative, one bit per cycle. Operands are accepted, and the result and writeback tag are returned, over valid/ready handshakes. It sits between register-file read and writeback.

## Interface
- `XLEN`, 32, datapath width; power of two, ≥ 8; shift amount is `rs2[$clog2(XLEN)-1:0]`.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands and control valid.
- `in_ready`  out  1  unit can accept an operation.
- `alu_control`  in  4  operation code from the decoder.
- `regwrite_control`  in  1  destination write requested.
- `rs1`, `rs2`  in  XLEN  operands; `rs2` is the shift amount for shifts and the mask for GRUP/DEGRUP.
- `in_rd`  in  5  destination register tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  writeback accepts the result.
- `result`  out  XLEN  operation result.
- `out_rd`  out  5  tag passed through.
- `out_regwrite`  out  1  write enable for writeback.
- `zero`  out  1  `result == 0`.
- `illegal`  out  1  unsupported `alu_control` code.

## Operation
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL (logical), 0111 XOR: single-cycle.
  - 0110 MUL: iterative. Result is the low XLEN bits of the unsigned product.
  - 1001 GRUP, 1010 DEGRUP: iterative.
- Add, sub and mul wrap modulo 2^XLEN. No overflow output.
- GRUP semantics:
  - Let m = `rs2` and z = popcount(~m).
  - `result[z-1:0]` holds the bits of `rs1` at positions where m=0, in ascending order.
  - `result[XLEN-1:z]` holds the bits at positions where m=1, in ascending order.
- DEGRUP is the exact inverse: DEGRUP(GRUP(a,m),m) = a.
- Any other code sets `illegal`=1, `result`=0 and `out_regwrite`=0. It completes in one cycle.
- States:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`, latch the operands, code, `in_rd` and `regwrite_control`.
    - Single-cycle or illegal code → DONE, with the result registered.
    - Iterative code → BUSY, with `count`=0.
  - BUSY:
    - One operand bit is processed per cycle; `count` increments.
    - At `count`=XLEN-1 the final result is registered → DONE.
  - DONE:
    - `out_valid`=1, with outputs held stable.
    - On `out_ready` → IDLE.
- `in_ready`=0 in BUSY and DONE. There is no overlap and no same-cycle re-accept in DONE.
- `out_regwrite` = latched `regwrite_control` & ~`illegal`.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - State → IDLE.
  - `in_ready`=1 after reset.
  - `out_valid`, `result`, `out_rd`, `out_regwrite`, `zero`, `illegal` and `count` all → 0.
  - Any in-flight operation is discarded.
- Latency, measured from the accept edge N:
  - Single-cycle ops: `out_valid` from edge N+1.
  - Iterative ops: `out_valid` from edge N+XLEN+1.
- If `out_ready` is held low, DONE persists indefinitely with the result stable.
- `out_ready` asserted on the first `out_valid` cycle gives back-to-back throughput:
  - 1 op per 2 cycles for single-cycle ops.
  - 1 op per XLEN+2 cycles for iterative ops.
- Shift amount ≥ XLEN cannot occur, because only the low `$clog2(XLEN)` bits of `rs2` are used.
- Shift amount 0 returns `rs1` unchanged.
- `zero` is registered together with `result`.

## Configuration
- Macro: `BITMANIP_ALU_GRUP_EN`.
- Defined: GRUP and DEGRUP are implemented as described above.
- Undefined:
  - Codes 1001 and 1010 are treated as illegal: `illegal`=1, `result`=0, `out_regwrite`=0, single-cycle.
  - The iterative grouping datapath is removed.
  - MUL is unaffected.

## Structure
- Shared package `bitmanip_pkg`:
  - `alu_control` code constants (ALU_AND … ALU_DEGRUP).
  - The state enum (IDLE/BUSY/DONE).
  - The XLEN default.
- Sub-module `bitmanip_grup_iter` (only when the macro is defined):
  - Holds the per-bit pack/unpack pointers, initialised from popcount(~mask) at start.
  - Takes the start/step from the parent FSM.
  - MUL shift-add stays in the parent.

## Test plan
- Reset mid-MUL:
  - Accept MUL, assert `reset_n`=0 at cycle 10.
  - Required: all outputs 0 next edge, `in_ready`=1, and no `out_valid` later.
- SUB with backpressure:
  - Stimulus: SUB `rs1`=5, `rs2`=7, `out_ready`=0 for 5 cycles.
  - Required: `result`=0xFFFFFFFE, `zero`=0, stable while stalled.
  - Required: IDLE the cycle after `out_ready`.
- MUL:
  - Stimulus: 0x0000FFFF × 0x00010001.
  - Required: `result`=0xFFFFFFFF with `out_valid` exactly XLEN+1 cycles after accept.
- GRUP round-trip:
  - GRUP `rs1`=0x12345678, `rs2`=0x0000FF00 → 0x56123478.
  - DEGRUP 0x56123478 with the same mask → 0x12345678.
- Illegal code and tag pass-through:
  - Stimulus: `alu_control`=1111, `regwrite_control`=1, `in_rd`=9.
  - Required: `illegal`=1, `result`=0, `out_regwrite`=0, `out_rd`=9, latency 1.
  - Repeat with code 1001 and the macro undefined: same response.
- Shift edge cases:
  - SLL 0x80000001 by `rs2`=0x21 (amount 1) → 0x00000002.
  - SRL by amount 0 → `rs1` unchanged.
